// File: rtl/imem_axi_rd_responder.sv
// imem_axi_rd_responder
//   AXI4 read-only responder backed by a word-addressed instruction store.
//   Accepts one INCR burst at a time on AR and returns arlen+1 beats on R.
//   The store is filled through a simple preload write port.
//
// Ports
//   clk, reset (async, active-low)
//   s_araddr/s_arlen/s_arvalid/s_arready       AR channel
//   s_rdata/s_rresp/s_rlast/s_rvalid/s_rready  R channel
//   ld_wr_en/ld_wr_addr/ld_wr_data             preload write port
//   busy            burst accepted and not yet fully returned
//   burst_done_cnt  number of completed bursts (rlast handshakes), wrapping
module imem_axi_rd_responder #(
    parameter int                         AXI_ADDR_WIDTH  = 42,
    parameter int                         AXI_DATA_WIDTH  = 64,
    parameter int                         AXI_BURST_WIDTH = 8,
    parameter int                         MEM_ADDR_WIDTH  = 10,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
    parameter int                         CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXI_BURST_WIDTH-1:0] s_arlen,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rlast,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    input  logic                       ld_wr_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  ld_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]  ld_wr_data,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       burst_done_cnt
);

    localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
    // Size of the store in bytes, one bit wider than the address so it cannot overflow.
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES =
        {{(AXI_ADDR_WIDTH - MEM_ADDR_WIDTH - OFF_W){1'b0}}, 1'b1, {(MEM_ADDR_WIDTH + OFF_W){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                     state;
    logic                       arready_q;
    logic [AXI_BURST_WIDTH-1:0] len_q;
    logic                       err_q;
    logic [AXI_BURST_WIDTH:0]   issue_cnt;
    logic [MEM_ADDR_WIDTH-1:0]  rd_word;

    logic [AXI_DATA_WIDTH-1:0]  mem [DEPTH];

    // Store read in flight (stage p1)
    logic                       rd_vld_p1;
    logic                       rd_last_p1;
    logic                       rd_err_p1;
    logic [AXI_DATA_WIDTH-1:0]  mem_rdata_p1;

    // Two-entry output skid buffer
    logic [AXI_DATA_WIDTH-1:0]  fifo_data [2];
    logic [1:0]                 fifo_err;
    logic [1:0]                 fifo_last;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 count;
    logic [CNT_WIDTH-1:0]       done_cnt;

    logic [AXI_ADDR_WIDTH-1:0]  ar_off;
    logic                       ar_in_range;
    logic                       pop;
    logic [2:0]                 occ;
    logic                       issue;
    logic                       issue_last;

    always_comb begin
        ar_off      = s_araddr - BASE_ADDR;
        ar_in_range = (s_araddr >= BASE_ADDR) && ({1'b0, ar_off} < MEM_BYTES);
        pop         = s_rvalid && s_rready;
        // Buffered beats plus the read in flight; a new read is allowed only if
        // it is guaranteed a slot when it lands, counting a pop this cycle.
        occ         = {1'b0, count} + {2'b00, rd_vld_p1};
        issue       = (state == FETCH) && ((occ < 3'd2) || ((occ == 3'd2) && pop));
        issue_last  = (issue_cnt == {1'b0, len_q});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            arready_q  <= 1'b0;
            len_q      <= '0;
            err_q      <= 1'b0;
            issue_cnt  <= '0;
            rd_word    <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            rd_err_p1  <= 1'b0;
            fifo_err   <= '0;
            fifo_last  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_arvalid && arready_q) begin
                        state     <= FETCH;
                        arready_q <= 1'b0;
                        len_q     <= s_arlen;
                        err_q     <= !ar_in_range;
                        rd_word   <= ar_off[OFF_W +: MEM_ADDR_WIDTH];
                        issue_cnt <= '0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        rd_word   <= rd_word + 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && s_rlast) begin
                        state     <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // stage p0 -> p1: read issued to the store
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue_last;
            rd_err_p1  <= err_q;

            // stage p1 -> buffer: read data lands in the skid buffer
            if (rd_vld_p1) begin
                fifo_err[wr_ptr]  <= rd_err_p1;
                fifo_last[wr_ptr] <= rd_last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_vld_p1} - {1'b0, pop};

            if (pop && s_rlast) done_cnt <= done_cnt + 1'b1;
        end
    end

    // Store and buffer data carry no reset; validity is tracked by the control above.
    // Non-blocking read and write give read-first behaviour on a same-word collision.
    always_ff @(posedge clk) begin
        if (ld_wr_en) mem[ld_wr_addr] <= ld_wr_data;
        if (issue) mem_rdata_p1 <= mem[rd_word];
        if (rd_vld_p1) fifo_data[wr_ptr] <= rd_err_p1 ? '0 : mem_rdata_p1;
    end

    assign s_arready      = arready_q;
    assign s_rvalid       = (count != 2'd0);
    assign s_rdata        = s_rvalid ? fifo_data[rd_ptr] : '0;
    assign s_rresp        = (s_rvalid && fifo_err[rd_ptr]) ? 2'b10 : 2'b00;
    assign s_rlast        = s_rvalid && fifo_last[rd_ptr];
    assign busy           = (state != IDLE);
    assign burst_done_cnt = done_cnt;

endmodule

// File: tb/tb_imem_axi_rd_responder.sv
module tb_imem_axi_rd_responder;

    localparam int AW = 42;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int MW = 10;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] s_araddr;
    logic [BW-1:0] s_arlen;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic          s_rvalid;
    logic          s_rready;
    logic          ld_wr_en;
    logic [MW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_wr_data;
    logic          busy;
    logic [CW-1:0] burst_done_cnt;

    imem_axi_rd_responder dut (
        .clk(clk), .reset(reset),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
        .busy(busy), .burst_done_cnt(burst_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        int            mode;   // 0 rready=1, 1 pattern 1,0,0,1, 2 random, 3 held low
        logic [1:0]    resp;
    } vec_t;

    beat_t         exp_q[$];
    beat_t         head;
    vec_t          vecs[10];
    logic [DW-1:0] mdl[1024];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            rmode = 0;
    int            phase = 0;
    int            beats_seen = 0;
    int            exp_cnt = 0;

    // rready generator, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        phase = phase + 1;
        case (rmode)
            0:       s_rready = 1'b1;
            1:       s_rready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2:       s_rready = 1'($urandom_range(0, 1));
            default: s_rready = 1'b0;
        endcase
    end

    // Scoreboard: every valid cycle is compared with the head of the queue,
    // so a stalled beat must stay equal to its expectation until accepted.
    always @(negedge clk) begin
        if (reset && s_rvalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got rdata=%h rlast=%b, required no beat", s_rdata, s_rlast);
            end else begin
                head = exp_q[0];
                if (s_rdata !== head.data || s_rresp !== head.resp || s_rlast !== head.last) begin
                    n_fail++;
                    $display("FAIL r_beat: got data=%h resp=%b last=%b, required data=%h resp=%b last=%b",
                             s_rdata, s_rresp, s_rlast, head.data, head.resp, head.last);
                end
                if (s_rready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [BW-1:0] l, input logic [1:0] r);
        int            k;
        logic [MW-1:0] w;
        logic [MW-1:0] idx;
        beat_t         b;
        @(negedge clk);
        s_araddr  = a;
        s_arlen   = l;
        s_arvalid = 1'b1;
        k = 0;
        while (!s_arready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!s_arready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ar_handshake: got arready=0 for 100 cycles, required 1");
            s_arvalid = 1'b0;
            return;
        end
        w = a[3 +: MW];
        for (int i = 0; i <= int'(l); i++) begin
            idx    = w + MW'(i);
            b.data = (r == 2'b00) ? mdl[idx] : '0;
            b.resp = r;
            b.last = (i == int'(l));
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1 s_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL burst_timeout: got %0d beats outstanding busy=%b, required 0 and 0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{42'h0,            8'd7,   0, 2'b00};
        vecs[1] = '{42'h0,            8'd7,   1, 2'b00};
        vecs[2] = '{42'd40,           8'd0,   0, 2'b00};
        vecs[3] = '{42'(8*1022),      8'd3,   0, 2'b00};
        vecs[4] = '{42'(8*1024),      8'd2,   0, 2'b10};
        vecs[5] = '{42'(8*3+5),       8'd2,   2, 2'b00};
        vecs[6] = '{42'h3FF_FFFF_FFF8, 8'd1,  2, 2'b10};
        vecs[7] = '{42'(8*1000),      8'd40,  2, 2'b00};
        vecs[8] = '{42'(8*100),       8'd255, 1, 2'b00};
        vecs[9] = '{42'(8*1024-1),    8'd1,   0, 2'b00};

        reset = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        ld_wr_en = 1'b0; ld_wr_addr = '0; ld_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_arready", 64'(s_arready), 64'd0);
        chk("reset_rvalid",  64'(s_rvalid),  64'd0);
        chk("reset_rlast",   64'(s_rlast),   64'd0);
        chk("reset_rresp",   64'(s_rresp),   64'd0);
        chk("reset_rdata",   s_rdata,        64'd0);
        chk("reset_busy",    64'(busy),      64'd0);
        chk("reset_cnt",     64'(burst_done_cnt), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ld_wr_en   = 1'b1;
            ld_wr_addr = MW'(i);
            ld_wr_data = (i < 8) ? 64'h1000 + 64'(i) : 64'hC0DE_0000_0000_0000 | 64'(i * 7);
            mdl[i]     = ld_wr_data;
        end
        @(negedge clk);
        ld_wr_en = 1'b0;
        chk("idle_arready", 64'(s_arready), 64'd1);

        // First-beat latency: handshake at edge T, rvalid low after T+1, high after T+2
        rmode = 0;
        send_ar(42'h0, 8'd7, 2'b00);
        @(negedge clk);
        chk("latency_t0", 64'(s_rvalid), 64'd0);
        @(negedge clk);
        chk("latency_t1", 64'(s_rvalid), 64'd0);
        @(negedge clk);
        chk("latency_t2", 64'(s_rvalid), 64'd1);
        wait_idle();
        exp_cnt++;
        chk("cnt_latency_burst", 64'(burst_done_cnt), 64'(exp_cnt));

        for (int v = 0; v < 10; v++) begin
            rmode = vecs[v].mode;
            send_ar(vecs[v].addr, vecs[v].len, vecs[v].resp);
            wait_idle();
            exp_cnt++;
            chk($sformatf("cnt_vec%0d", v), 64'(burst_done_cnt), 64'(exp_cnt));
        end

        // Single beat held back: no new AR accepted until it is taken
        rmode = 3;
        send_ar(42'd40, 8'd0, 2'b00);
        repeat (5) @(negedge clk);
        chk("stall_arready", 64'(s_arready), 64'd0);
        chk("stall_busy",    64'(busy),      64'd1);
        chk("stall_rvalid",  64'(s_rvalid),  64'd1);
        rmode = 0;
        wait_idle();
        exp_cnt++;
        @(negedge clk);
        chk("after_single_arready", 64'(s_arready), 64'd1);
        chk("cnt_single", 64'(burst_done_cnt), 64'(exp_cnt));

        // Reset in the middle of an 8-beat burst
        rmode = 0;
        beats_seen = 0;
        send_ar(42'h0, 8'd7, 2'b00);
        for (int k = 0; k < 50 && beats_seen < 3; k++) @(negedge clk);
        chk("midburst_beats_seen", 64'(beats_seen >= 3), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midreset_rvalid",  64'(s_rvalid),  64'd0);
        chk("midreset_busy",    64'(busy),      64'd0);
        chk("midreset_arready", 64'(s_arready), 64'd0);
        chk("midreset_cnt",     64'(burst_done_cnt), 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rmode = 2;
        send_ar(42'h0, 8'd7, 2'b00);
        wait_idle();
        exp_cnt++;
        chk("cnt_after_reset", 64'(burst_done_cnt), 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
